// File: rtl/step_control_unit.sv
// ---------------------------------------------------------------------------
// step_control_unit
//   Control unit for a simple 9-bit multicycle processor. It consumes the step
//   count from an external 3-bit step counter, holds the instruction register
//   and decodes the current instruction into datapath enables. It also drives
//   the counter's synchronous Clear, so every instruction ends back at T0.
//
//   Instruction word: III XXX YYY
//     000 mv  Rx,Ry   001 mvi Rx,#D   010 add Rx,Ry   011 sub Rx,Ry
//     1xx undefined, executed as a NOP
//
// Ports
//   Clock   in   system clock, rising edge
//   Resetn  in   asynchronous active-low reset
//   Run     in   start request, sampled only at T0
//   DIN     in   instruction word at T0, immediate data at T1 of mvi
//   Tstep   in   current step from the step counter
//   IR      out  registered instruction
//   IRin    out  IR load strobe
//   Rout    out  one-hot register-to-bus select
//   Rin     out  one-hot register load enable
//   Ain     out  load A
//   Gin     out  load G
//   Gout    out  G drives the bus
//   DINout  out  DIN drives the bus
//   AddSub  out  ALU op, 0 = add, 1 = sub
//   Done    out  last step of the instruction
//   Clear   out  synchronous clear request to the step counter
// ---------------------------------------------------------------------------
module step_control_unit #(
  parameter int DATA_W   = 9,
  parameter int NUM_REGS = 8
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Run,
  input  logic [DATA_W-1:0]   DIN,
  input  logic [2:0]          Tstep,
  output logic [DATA_W-1:0]   IR,
  output logic                IRin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic                Ain,
  output logic                Gin,
  output logic                Gout,
  output logic                DINout,
  output logic                AddSub,
  output logic                Done,
  output logic                Clear
);

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } opcode_t;

  logic [DATA_W-1:0]   r_ir;
  logic [2:0]          w_op;
  logic [2:0]          w_x;
  logic [2:0]          w_y;
  logic [NUM_REGS-1:0] w_x_sel;
  logic [NUM_REGS-1:0] w_y_sel;
  logic                w_is_alu;
  logic                w_ir_load;

  assign w_op     = r_ir[8:6];
  assign w_x      = r_ir[5:3];
  assign w_y      = r_ir[2:0];
  assign w_x_sel  = NUM_REGS'(1) << w_x;
  assign w_y_sel  = NUM_REGS'(1) << w_y;
  assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB);

  // The flop enable is kept free of Resetn: while reset is asserted the flop is
  // held cleared anyway, and the exported IRin is gated separately below.
  assign w_ir_load = (Tstep == 3'd0) && Run;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_ir <= '0;
    end else if (w_ir_load) begin
      r_ir <= DIN;
    end
  end

  assign IR = r_ir;

  always_comb begin
    IRin   = 1'b0;
    Rout   = '0;
    Rin    = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    DINout = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
    Clear  = 1'b0;

    // Reset gates every enable combinationally, so an aborted instruction
    // cannot write the datapath after Resetn falls.
    if (!Resetn) begin
      Clear = 1'b1;
    end else begin
      unique case (Tstep)
        3'd0: begin
          if (Run) IRin  = 1'b1;
          else     Clear = 1'b1;
        end
        3'd1: begin
          case (w_op)
            OP_MV: begin
              Rout  = w_y_sel;
              Rin   = w_x_sel;
              Done  = 1'b1;
              Clear = 1'b1;
            end
            OP_MVI: begin
              DINout = 1'b1;
              Rin    = w_x_sel;
              Done   = 1'b1;
              Clear  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              Rout = w_x_sel;
              Ain  = 1'b1;
            end
            default: begin
              Done  = 1'b1;
              Clear = 1'b1;
            end
          endcase
        end
        3'd2: begin
          if (w_is_alu) begin
            Rout   = w_y_sel;
            Gin    = 1'b1;
            AddSub = (w_op == OP_SUB);
          end else begin
            Clear = 1'b1;
          end
        end
        3'd3: begin
          if (w_is_alu) begin
            Gout  = 1'b1;
            Rin   = w_x_sel;
            Done  = 1'b1;
            Clear = 1'b1;
          end else begin
            Clear = 1'b1;
          end
        end
        // Steps 4..7 only appear if the counter is corrupted: recover to T0.
        default: begin
          Clear = 1'b1;
        end
      endcase
    end
  end

endmodule
